hdc302x_i2c_slave: RTL

Synthesizable I2C responder that models the HDC302x sensor at the far end of the bus driven by hdc302x_i2c_master. It accepts a 2-byte command write, runs a timed "measurement", and returns the 6-byte result frame on read: T_MSB, T_LSB, CRC, H_MSB, H_LSB, CRC. It is used as the slave model in simulation and as an FPGA loopback target for bring-up.

---
 rtl/hdc302x_pkg.sv | 20 ++
 rtl/hdc302x_i2c_slave_crc8.sv | 20 ++
 rtl/hdc302x_i2c_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hdc302x_pkg.sv
// Shared definitions for the HDC302x I2C responder:
// FSM encoding, command constants and CRC parameters.
package hdc302x_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_CMD_RX   = 4'd3,
    ST_CMD_ACK  = 4'd4,
    ST_TX_BYTE  = 4'd5,
    ST_TX_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } state_e;

  localparam logic [15:0] CMD_TRIG_HR = 16'h2400;
  localparam logic [7:0]  CRC_POLY    = 8'h31;
  localparam logic [7:0]  CRC_INIT    = 8'hFF;

endpackage

// File: rtl/hdc302x_i2c_slave_crc8.sv
// Combinational CRC-8 over a 16-bit word, MSB first,
// no reflection and no final XOR.
module hdc302x_crc8
  import hdc302x_pkg::*;
(
  input  logic [15:0] data_i,
  output logic [7:0]  crc_o
);

  always_comb begin
    crc_o = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc_o[7] ^ data_i[i])
        crc_o = {crc_o[6:0], 1'b0} ^ CRC_POLY;
      else
        crc_o = {crc_o[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/hdc302x_i2c_slave.sv
// HDC302x I2C responder: command write, timed measurement, 6-byte frame read.
// Optional HDC302X_SLAVE_NACK_BUSY_EN: NACK a read address while measuring.
module hdc302x_i2c_slave
  import hdc302x_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h44,
  parameter int         MEAS_CYCLES = 500000,
  parameter logic [7:0] TRIG_MSB    = 8'h24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  input  logic [15:0] hum_data,
  output logic        cmd_valid,
  output logic [15:0] cmd_code,
  output logic        meas_busy,
  output logic [3:0]  state_debug
);

  localparam int CW = $clog2(MEAS_CYCLES + 1);

  logic [1:0]  scl_s_q, sda_s_q;
  logic        scl_p_q, sda_p_q;
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        oe_q, oe_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  cmd_b0_q, cmd_b0_d;
  logic        cmd_fire;
  logic [15:0] cmd_new_q;
  logic [1:0]  pipe_q;
  logic        cmd_valid_q;
  logic [15:0] cmd_code_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] t_q, h_q;
  logic [7:0]  crc_t, crc_h, tx_byte;
  logic        scl_rise, scl_fall, start, stop;
  logic        sda_in, addr_hit;

  hdc302x_crc8 u_crc_t (.data_i(t_q), .crc_o(crc_t));
  hdc302x_crc8 u_crc_h (.data_i(h_q), .crc_o(crc_h));

  assign sda_in   = sda_s_q[1];
  assign scl_rise = scl_s_q[1] & ~scl_p_q;
  assign scl_fall = ~scl_s_q[1] & scl_p_q;
  assign start    = scl_s_q[1] & scl_p_q & sda_p_q & ~sda_in;
  assign stop     = scl_s_q[1] & scl_p_q & ~sda_p_q & sda_in;

`ifdef HDC302X_SLAVE_NACK_BUSY_EN
  assign addr_hit = (shift_q[7:1] == SLAVE_ADDR) && !(shift_q[0] && meas_busy);
`else
  assign addr_hit = (shift_q[7:1] == SLAVE_ADDR);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s_q     <= 2'b11;
      sda_s_q     <= 2'b11;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      oe_q        <= 1'b0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      cmd_b0_q    <= '0;
      cmd_new_q   <= '0;
      pipe_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cnt_q       <= '0;
      t_q         <= '0;
      h_q         <= '0;
    end else begin
      scl_s_q     <= {scl_s_q[0], scl};
      sda_s_q     <= {sda_s_q[0], sda};
      scl_p_q     <= scl_s_q[1];
      sda_p_q     <= sda_s_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      oe_q        <= oe_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_b0_q    <= cmd_b0_d;
      if (cmd_fire) cmd_new_q <= {cmd_b0_q, shift_q};
      // two-stage delay sets the command-to-cmd_valid latency
      pipe_q      <= {pipe_q[0], cmd_fire};
      cmd_valid_q <= pipe_q[1];
      if (pipe_q[1]) cmd_code_q <= cmd_new_q;
      if (pipe_q[1] && cmd_new_q[15:8] == TRIG_MSB) begin
        cnt_q <= CW'(MEAS_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          t_q <= temp_data;
          h_q <= hum_data;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    cmd_b0_d   = cmd_b0_q;
    cmd_fire   = 1'b0;
    if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR, ST_CMD_RX: begin
          shift_d   = {shift_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        ST_CMD_ACK: cmd_fire = (byte_cnt_q == 2'd1);
        ST_TX_BYTE: bit_cnt_d = bit_cnt_q + 4'd1;
        ST_TX_ACK: begin
          if (sda_in) begin
            state_d = ST_IGNORE;
          end else begin
            state_d   = ST_TX_BYTE;
            bit_cnt_d = '0;
            ptr_d     = (ptr_q == 3'd7) ? ptr_q : ptr_q + 3'd1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        ST_ADDR: begin
          if (bit_cnt_q == 4'd8) begin
            if (addr_hit) begin
              state_d    = ST_ADDR_ACK;
              oe_d       = 1'b1;
              ptr_d      = '0;
              byte_cnt_d = '0;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          bit_cnt_d = '0;
          if (shift_q[0]) begin
            state_d = ST_TX_BYTE;
            oe_d    = ~tx_byte[7];
          end else begin
            state_d = ST_CMD_RX;
            oe_d    = 1'b0;
          end
        end
        ST_CMD_RX: begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_CMD_ACK;
            oe_d      = 1'b1;
            bit_cnt_d = '0;
            if (byte_cnt_q == 2'd0) cmd_b0_d = shift_q;
          end
        end
        ST_CMD_ACK: begin
          state_d = ST_CMD_RX;
          oe_d    = 1'b0;
          if (byte_cnt_q != 2'd2) byte_cnt_d = byte_cnt_q + 2'd1;
        end
        ST_TX_BYTE: begin
          if (bit_cnt_q == 4'd8) begin
            state_d = ST_TX_ACK;
            oe_d    = 1'b0;
          end else begin
            oe_d = ~tx_byte[3'd7 - bit_cnt_q[2:0]];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (ptr_q)
      3'd0:    tx_byte = t_q[15:8];
      3'd1:    tx_byte = t_q[7:0];
      3'd2:    tx_byte = crc_t;
      3'd3:    tx_byte = h_q[15:8];
      3'd4:    tx_byte = h_q[7:0];
      3'd5:    tx_byte = crc_h;
      default: tx_byte = 8'hFF;
    endcase
  end

  // reset releases the bus without waiting for the clock edge
  assign sda         = (oe_q && !rst) ? 1'b0 : 1'bz;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign meas_busy   = (cnt_q != '0);
  assign state_debug = 4'(state_q);

endmodule
